// File: rtl/object_line_scheduler.sv
// Per-scanline object scheduler: scans every object entry during hblank, collects up to SLOTS
// hits for the target line in a shadow list, and publishes that list to the renderers on line_swap.
module object_line_scheduler #(
  parameter int OBJ_LIMIT = 8,
  parameter int SLOTS     = 4,
  parameter int SPRITE_H  = 32,
  parameter int IDX_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_start,
  input  logic [9:0]               next_line,
  input  logic                     line_swap,
  input  logic [OBJ_LIMIT-1:0]     obj_active,
  input  logic [OBJ_LIMIT*10-1:0]  obj_y,
  output logic [SLOTS-1:0]         slot_valid,
  output logic [SLOTS*IDX_W-1:0]   slot_idx,
  output logic [SLOTS*5-1:0]       slot_row,
  output logic                     scan_busy,
  output logic                     scan_done,
  output logic                     overflow,
  output logic                     swap_miss
);

  // state | meaning
  // IDLE  | waiting for line_start
  // SCAN  | evaluating object idx_q, one per cycle
  // DONE  | scan finished, shadow list ready to publish
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] SLOTS_C  = CNT_W'(SLOTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OBJ_LIMIT - 1);

  logic [1:0]               state_q, state_d;
  logic [9:0]               tgt_q, tgt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SLOTS*IDX_W-1:0]   sh_idx_q, sh_idx_d;
  logic [SLOTS*5-1:0]       sh_row_q, sh_row_d;
  logic                     ready_q, ready_d;
  logic [SLOTS-1:0]         pub_valid_q, pub_valid_d;
  logic [SLOTS*IDX_W-1:0]   pub_idx_q, pub_idx_d;
  logic [SLOTS*5-1:0]       pub_row_q, pub_row_d;
  logic                     ovf_q, ovf_d;
  logic                     miss_q, miss_d;

  logic [9:0]  cur_y;
  logic [10:0] diff;
  logic        hit;

  // 11-bit compare keeps y + SPRITE_H from wrapping near the bottom of the 10-bit range
  always_comb begin
    cur_y = obj_y[int'(idx_q)*10 +: 10];
    diff  = {1'b0, tgt_q} - {1'b0, cur_y};
    hit   = obj_active[idx_q]
            && ({1'b0, tgt_q} >= {1'b0, cur_y})
            && ({1'b0, tgt_q} < ({1'b0, cur_y} + 11'(SPRITE_H)));
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    sh_idx_d    = sh_idx_q;
    sh_row_d    = sh_row_q;
    ready_d     = ready_q;
    pub_valid_d = pub_valid_q;
    pub_idx_d   = pub_idx_q;
    pub_row_d   = pub_row_q;
    ovf_d       = ovf_q;
    miss_d      = miss_q;

    if (line_swap) begin
      if (ready_q) begin
        for (int s = 0; s < SLOTS; s++) pub_valid_d[s] = (CNT_W'(s) < cnt_q);
        pub_idx_d = sh_idx_q;
        pub_row_d = sh_row_q;
        ready_d   = 1'b0;
      end else begin
        pub_valid_d = '0;
        pub_idx_d   = '0;
        pub_row_d   = '0;
        miss_d      = 1'b1;
      end
    end

    case (state_q)
      S_SCAN: begin
        if (hit) begin
          if (cnt_q < SLOTS_C) begin
            sh_idx_d[int'(cnt_q)*IDX_W +: IDX_W] = idx_q;
            sh_row_d[int'(cnt_q)*5 +: 5]         = diff[4:0];
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // a new scan always wins, aborting whatever was in progress
    if (line_start) begin
      state_d  = S_SCAN;
      tgt_d    = next_line;
      idx_d    = '0;
      cnt_d    = '0;
      sh_idx_d = '0;
      sh_row_d = '0;
      ready_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tgt_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      sh_idx_q    <= '0;
      sh_row_q    <= '0;
      ready_q     <= 1'b0;
      pub_valid_q <= '0;
      pub_idx_q   <= '0;
      pub_row_q   <= '0;
      ovf_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      sh_idx_q    <= sh_idx_d;
      sh_row_q    <= sh_row_d;
      ready_q     <= ready_d;
      pub_valid_q <= pub_valid_d;
      pub_idx_q   <= pub_idx_d;
      pub_row_q   <= pub_row_d;
      ovf_q       <= ovf_d;
      miss_q      <= miss_d;
    end
  end

  assign slot_valid = pub_valid_q;
  assign slot_idx   = pub_idx_q;
  assign slot_row   = pub_row_q;
  assign scan_busy  = (state_q == S_SCAN);
  assign scan_done  = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign swap_miss  = miss_q;

endmodule

// File: tb/tb_object_line_scheduler.sv
// Directed bench for object_line_scheduler; inputs change and outputs are sampled on the falling edge.
module tb_object_line_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  next_line = '0;
  logic        line_swap = 1'b0;
  logic [7:0]  obj_active = '0;
  logic [79:0] obj_y = '0;
  logic [3:0]  slot_valid;
  logic [11:0] slot_idx;
  logic [19:0] slot_row;
  logic        scan_busy, scan_done, overflow, swap_miss;

  int total = 0;
  int bad = 0;
  int done_cyc, done_cnt;
  logic [31:0] busy_v;

  always #5 clk = ~clk;

  object_line_scheduler dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_line(next_line),
    .line_swap(line_swap), .obj_active(obj_active), .obj_y(obj_y),
    .slot_valid(slot_valid), .slot_idx(slot_idx), .slot_row(slot_row),
    .scan_busy(scan_busy), .scan_done(scan_done), .overflow(overflow), .swap_miss(swap_miss)
  );

  task automatic set_obj(input int k, input logic act, input logic [9:0] y);
    obj_active[k]     = act;
    obj_y[k*10 +: 10] = y;
  endtask

  // Observation k happens at the falling edge inside cycle k (line_start is high in cycle 0).
  // swap_at = 0 pulses line_swap together with line_start; negative disables.
  task automatic run_scan(input logic [9:0] line, input int swap_at, input int restart_at,
                          input logic [9:0] rline);
    done_cyc = -1;
    done_cnt = 0;
    busy_v   = '0;
    @(negedge clk);
    line_start = 1'b1;
    next_line  = line;
    line_swap  = (swap_at == 0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      line_start = 1'b0;
      line_swap  = 1'b0;
      busy_v[k]  = scan_busy;
      if (scan_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == swap_at) line_swap = 1'b1;
      if (k == restart_at) begin
        line_start = 1'b1;
        next_line  = rline;
      end
    end
  endtask

  task automatic do_swap();
    @(negedge clk);
    line_swap = 1'b1;
    @(negedge clk);
    line_swap = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got %b want 0000", slot_valid); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", scan_busy); end
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", scan_done); end
    total++; if ({overflow, swap_miss} !== 2'b00) begin bad++; $display("FAIL reset_sticky got %b want 00", {overflow, swap_miss}); end
  endtask

  task automatic test_empty();
    obj_active = '0;
    run_scan(10'd100, -1, -1, 10'd0);
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL empty_done_cycle got %0d want 9", done_cyc); end
    total++; if (busy_v !== 32'h0000_01FE) begin bad++; $display("FAIL empty_busy got %h want 000001fe", busy_v); end
    do_swap();
    total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL empty_valid got %b want 0000", slot_valid); end
    total++; if ({overflow, swap_miss} !== 2'b00) begin bad++; $display("FAIL empty_sticky got %b want 00", {overflow, swap_miss}); end
  endtask

  task automatic test_two_hits();
    obj_active = '0;
    set_obj(2, 1'b1, 10'd90);
    set_obj(5, 1'b1, 10'd100);
    run_scan(10'd100, -1, -1, 10'd0);
    do_swap();
    total++; if (slot_valid !== 4'b0011) begin bad++; $display("FAIL two_valid got %b want 0011", slot_valid); end
    total++; if (slot_idx !== {3'd0, 3'd0, 3'd5, 3'd2}) begin bad++; $display("FAIL two_idx got %h want %h", slot_idx, {3'd0, 3'd0, 3'd5, 3'd2}); end
    total++; if (slot_row !== {5'd0, 5'd0, 5'd0, 5'd10}) begin bad++; $display("FAIL two_row got %h want %h", slot_row, {5'd0, 5'd0, 5'd0, 5'd10}); end
  endtask

  task automatic test_boundary();
    obj_active = '0;
    set_obj(0, 1'b1, 10'd68);
    set_obj(1, 1'b1, 10'd69);
    run_scan(10'd100, -1, -1, 10'd0);
    do_swap();
    total++; if (slot_valid !== 4'b0001) begin bad++; $display("FAIL edge_valid got %b want 0001", slot_valid); end
    total++; if ({slot_idx[2:0], slot_row[4:0]} !== {3'd1, 5'd31}) begin bad++; $display("FAIL edge_slot0 got %0d/%0d want 1/31", slot_idx[2:0], slot_row[4:0]); end
    obj_active = '0;
    set_obj(3, 1'b1, 10'd1000);
    run_scan(10'd1020, -1, -1, 10'd0);
    do_swap();
    total++; if (slot_valid !== 4'b0001) begin bad++; $display("FAIL nowrap_valid got %b want 0001", slot_valid); end
    total++; if ({slot_idx[2:0], slot_row[4:0]} !== {3'd3, 5'd20}) begin bad++; $display("FAIL nowrap_slot0 got %0d/%0d want 3/20", slot_idx[2:0], slot_row[4:0]); end
  endtask

  task automatic test_back_to_back();
    obj_active = '0;
    set_obj(2, 1'b1, 10'd90);
    set_obj(5, 1'b1, 10'd100);
    run_scan(10'd100, -1, -1, 10'd0);
    run_scan(10'd125, 0, -1, 10'd0);
    total++; if (slot_valid !== 4'b0011) begin bad++; $display("FAIL b2b_old_valid got %b want 0011", slot_valid); end
    total++; if (slot_idx !== {3'd0, 3'd0, 3'd5, 3'd2}) begin bad++; $display("FAIL b2b_old_idx got %h want %h", slot_idx, {3'd0, 3'd0, 3'd5, 3'd2}); end
    total++; if (swap_miss !== 1'b0) begin bad++; $display("FAIL b2b_miss got %b want 0", swap_miss); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL b2b_done_cycle got %0d want 9", done_cyc); end
    do_swap();
    total++; if (slot_valid !== 4'b0001) begin bad++; $display("FAIL b2b_new_valid got %b want 0001", slot_valid); end
    total++; if ({slot_idx[2:0], slot_row[4:0]} !== {3'd5, 5'd25}) begin bad++; $display("FAIL b2b_new_slot0 got %0d/%0d want 5/25", slot_idx[2:0], slot_row[4:0]); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 8; k++) set_obj(k, 1'b1, 10'd100);
    run_scan(10'd115, -1, -1, 10'd0);
    do_swap();
    total++; if (slot_valid !== 4'b1111) begin bad++; $display("FAIL ovf_valid got %b want 1111", slot_valid); end
    total++; if (slot_idx !== {3'd3, 3'd2, 3'd1, 3'd0}) begin bad++; $display("FAIL ovf_idx got %h want %h", slot_idx, {3'd3, 3'd2, 3'd1, 3'd0}); end
    total++; if (slot_row !== {5'd15, 5'd15, 5'd15, 5'd15}) begin bad++; $display("FAIL ovf_row got %h want %h", slot_row, {5'd15, 5'd15, 5'd15, 5'd15}); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    run_scan(10'd500, -1, -1, 10'd0);
    do_swap();
    total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL ovf_next_valid got %b want 0000", slot_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_swap_mid_scan();
    obj_active = '0;
    set_obj(2, 1'b1, 10'd90);
    set_obj(5, 1'b1, 10'd100);
    run_scan(10'd100, 4, -1, 10'd0);
    total++; if (slot_valid !== 4'b0000) begin bad++; $display("FAIL mid_valid got %b want 0000", slot_valid); end
    total++; if (swap_miss !== 1'b1) begin bad++; $display("FAIL mid_miss got %b want 1", swap_miss); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL mid_done_cycle got %0d want 9", done_cyc); end
    do_swap();
    total++; if (slot_valid !== 4'b0011) begin bad++; $display("FAIL mid_pub_valid got %b want 0011", slot_valid); end
    total++; if (slot_row !== {5'd0, 5'd0, 5'd0, 5'd10}) begin bad++; $display("FAIL mid_pub_row got %h want %h", slot_row, {5'd0, 5'd0, 5'd0, 5'd10}); end
  endtask

  task automatic test_restart();
    run_scan(10'd100, -1, 3, 10'd125);
    total++; if (done_cyc !== 12) begin bad++; $display("FAIL restart_done_cycle got %0d want 12", done_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart_done_count got %0d want 1", done_cnt); end
    do_swap();
    total++; if (slot_valid !== 4'b0001) begin bad++; $display("FAIL restart_valid got %b want 0001", slot_valid); end
    total++; if ({slot_idx[2:0], slot_row[4:0]} !== {3'd5, 5'd25}) begin bad++; $display("FAIL restart_slot0 got %0d/%0d want 5/25", slot_idx[2:0], slot_row[4:0]); end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    line_start = 1'b1;
    next_line  = 10'd100;
    @(negedge clk);
    line_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got %b want 0", scan_busy); end
    total++; if ({slot_valid, overflow, swap_miss} !== 6'b0) begin bad++; $display("FAIL rmid_clear got %b want 000000", {slot_valid, overflow, swap_miss}); end
    repeat (10) @(negedge clk);
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL rmid_no_done got %b want 0", scan_done); end
    do_swap();
    total++; if (swap_miss !== 1'b1) begin bad++; $display("FAIL rmid_swap_miss got %b want 1", swap_miss); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_two_hits();
    test_boundary();
    test_back_to_back();
    test_overflow();
    test_swap_mid_scan();
    test_restart();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/object_line_scheduler.md
Name: object_line_scheduler

Overview:
- Per-scanline scheduler for the object layer. Inside each horizontal blanking interval it scans every alien entry, picks up to SLOTS objects that cover the next scanline (lowest index wins), and builds a double-buffered slot list.
- The sprite fetch/render units read the published list during the visible line, so only a few renderers are shared among OBJ_LIMIT objects.
- Sits between the datagram decode and layer_object; runs in the 25 MHz pixel clock domain.

Parameters:
- OBJ_LIMIT, 8, number of object entries scanned per line.
- SLOTS, 4, maximum objects rendered on one line.
- SPRITE_H, 32, sprite height in lines.
- IDX_W, 3, index width; must equal clog2(OBJ_LIMIT).

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  synchronous active-high reset.
- line_start  in  1  one-cycle pulse at start of hblank; begins a scan.
- next_line  in  10  scanline the scan targets; sampled on line_start.
- line_swap  in  1  one-cycle pulse at start of the visible line; publishes the shadow list.
- obj_active  in  OBJ_LIMIT  per-object active bit.
- obj_y  in  OBJ_LIMIT*10  per-object top y; object k is bits [10k+9:10k].
- slot_valid  out  SLOTS  published slot occupied.
- slot_idx  out  SLOTS*IDX_W  published object index per slot; slot s is bits [IDX_W*s+IDX_W-1:IDX_W*s].
- slot_row  out  SLOTS*5  row within sprite (next_line - obj_y) per slot; low 5 bits.
- scan_busy  out  1  high while in SCAN.
- scan_done  out  1  one-cycle pulse when a scan completes.
- overflow  out  1  sticky: more than SLOTS hits on some line since reset.
- swap_miss  out  1  sticky: line_swap arrived with no completed scan.

Behaviour:
- Reset: all outputs 0; published and shadow lists cleared; state IDLE; hit count 0; shadow_ready 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On line_start, latch next_line into tgt, clear shadow list and count, set idx=0, clear shadow_ready, go to SCAN.
- SCAN, one object per cycle:
  - Object idx hits iff obj_active[idx] and tgt >= y and tgt < y+SPRITE_H. The compare is done in 11 bits, so y near 1023 does not wrap.
  - On a hit with count<SLOTS: write shadow[count] = {idx, (tgt-y)[4:0]} and increment count.
  - On a hit with count==SLOTS: set overflow and drop the object.
  - When idx==OBJ_LIMIT-1, go to DONE; otherwise increment idx.
- DONE:
  - For one cycle, scan_done=1 and shadow_ready=1, then return to IDLE.
- Latency: with line_start at cycle 0, object k is evaluated in cycle k+1 and scan_done is high in cycle OBJ_LIMIT+1. scan_busy is high in cycles 1..OBJ_LIMIT.
- Ordering: slots fill in ascending object index, so slot 0 holds the lowest hit index. Slots at or above count publish as invalid.
- line_swap:
  - If shadow_ready: the published list takes the shadow contents (slot_valid bit s = s<count) on the next edge, and shadow_ready clears.
  - If not shadow_ready: the published list is cleared (all slot_valid=0) and swap_miss is set.
  - Published outputs change only on line_swap or reset.
- line_start during SCAN or DONE: abort the current scan and restart with the new next_line. No scan_done is issued for the aborted scan, and shadow_ready stays 0.
- line_swap and line_start in the same cycle: the swap uses the current shadow state first, then the new scan starts as normally; no data is lost.
- line_swap during SCAN: treated as a miss. The in-progress scan continues and does not publish until the next swap.
- Reset mid-scan: the scan is discarded, returns to IDLE, and everything clears within one cycle.
- overflow and swap_miss clear only on rst.

Test Plan:
- Reset, then line_start with next_line=100, all objects inactive -> scan_done exactly in cycle 9; after line_swap, slot_valid=0000; overflow=0, swap_miss=0.
- Objects 2 and 5 active with y=90 and y=100, next_line=100 -> after swap: slot_valid=0011, slot_idx[0]=2 with row 10, slot_idx[1]=5 with row 0.
- All 8 objects active with y=100, next_line=115 -> slots hold indices 0,1,2,3, all rows 15, overflow=1; the next line with no hits keeps overflow=1.
- Boundary: object 0 y=68, object 1 y=69, next_line=100 (SPRITE_H=32) -> only object 1 hits; object 3 y=1000 with next_line=1020 hits with row 20 and no wrap.
- line_swap at cycle 4 of a scan -> published list cleared, swap_miss=1; scan_done still pulses at cycle 9, and the next line_swap publishes that result.
- line_start re-pulsed at cycle 3 with a different next_line -> no scan_done at the original cycle 9; scan_done arrives 9 cycles after the second pulse, and its list reflects the new line only.
